// File: rtl/pc_core_rd_burst_ctrl_if.sv
// AXI4 read-side signals between the burst controller and the memory port:
// AR request channel plus the qualified R beat/last strobes.
interface pc_core_rd_burst_ctrl_if #(
  parameter int C_ADDR_WIDTH = 64
) ();
  logic                    m_arvalid;
  logic                    m_arready;
  logic [C_ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]              m_arlen;
  logic                    rd_beat;
  logic                    rd_last;

  modport master (
    output m_arvalid, m_araddr, m_arlen,
    input  m_arready, rd_beat, rd_last
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arlen,
    output m_arready, rd_beat, rd_last
  );
endinterface

// File: rtl/pc_core_rd_burst_ctrl.sv
// Splits a kernel read request into AXI4 AR bursts, caps in-flight bursts and
// pulses done once every requested beat has returned.
//
// state | meaning
// IDLE  | waiting for ctrl_start
// ISSUE | issuing AR bursts while beats remain to be requested
// DRAIN | all ARs issued, waiting for the last R beats to return
module pc_core_rd_burst_ctrl #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_BYTES_PER_BEAT  = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_beats,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic                         ctrl_err,
  pc_core_rd_burst_ctrl_if.master      axi
);

  localparam int                         ADDR_SHIFT  = $clog2(C_BYTES_PER_BEAT);
  localparam logic [7:0]                 MAX_LEN_M1  = 8'(C_BURST_LEN - 1);
  localparam logic [7:0]                 MAX_OUT     = 8'(C_MAX_OUTSTANDING);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] BURST_BEATS = C_XFER_SIZE_WIDTH'(C_BURST_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                       state_q;
  logic                         busy_q, done_q, err_q;
  logic                         ar_valid_q;
  logic [C_ADDR_WIDTH-1:0]      ar_addr_q;
  logic [7:0]                   ar_len_q;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining;
  logic [C_XFER_SIZE_WIDTH-1:0] xfer_q;
  logic [C_XFER_SIZE_WIDTH:0]   rcv_cnt;
  logic [7:0]                   outstanding;

  logic                         ar_hs, last_hs, dec_ok;
  logic [8:0]                   beats;
  logic [7:0]                   out_nxt;
  logic [C_XFER_SIZE_WIDTH-1:0] rem_nxt;
  logic [C_XFER_SIZE_WIDTH:0]   rcv_nxt;
  logic [C_ADDR_WIDTH-1:0]      addr_nxt;

  function automatic logic [7:0] len_m1(input logic [C_XFER_SIZE_WIDTH-1:0] beats_left);
    if (beats_left >= BURST_BEATS) return MAX_LEN_M1;
    return 8'(beats_left - C_XFER_SIZE_WIDTH'(1));
  endfunction

  // Next-cycle counter values; the FSM decides on these so that arvalid and
  // done react in the cycle right after the causing handshake.
  always_comb begin
    ar_hs    = ar_valid_q & axi.m_arready;
    last_hs  = axi.rd_beat & axi.rd_last;
    dec_ok   = last_hs && (outstanding != 8'd0);
    beats    = {1'b0, ar_len_q} + 9'd1;
    out_nxt  = outstanding;
    if (ar_hs && !dec_ok)      out_nxt = outstanding + 8'd1;
    else if (!ar_hs && dec_ok) out_nxt = outstanding - 8'd1;
    rem_nxt  = ar_hs ? remaining - C_XFER_SIZE_WIDTH'(beats) : remaining;
    addr_nxt = ar_addr_q + (C_ADDR_WIDTH'(beats) << ADDR_SHIFT);
    rcv_nxt  = (axi.rd_beat && busy_q) ? rcv_cnt + (C_XFER_SIZE_WIDTH+1)'(1) : rcv_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      remaining   <= '0;
      xfer_q      <= '0;
      rcv_cnt     <= '0;
      outstanding <= '0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= out_nxt;
      rcv_cnt     <= rcv_nxt;
      if ((axi.rd_beat && state_q == IDLE) || (last_hs && outstanding == 8'd0) ||
          (rcv_nxt > {1'b0, xfer_q}))
        err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (ctrl_start) begin
            xfer_q  <= ctrl_xfer_beats;
            rcv_cnt <= '0;
            err_q   <= 1'b0;
            if (ctrl_xfer_beats == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              busy_q     <= 1'b1;
              ar_valid_q <= 1'b1;
              ar_addr_q  <= ctrl_addr;
              ar_len_q   <= len_m1(ctrl_xfer_beats);
              remaining  <= ctrl_xfer_beats;
            end
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            ar_addr_q <= addr_nxt;
            remaining <= rem_nxt;
            if (rem_nxt == '0) state_q <= DRAIN;
            else               ar_len_q <= len_m1(rem_nxt);
          end
          ar_valid_q <= (rem_nxt != '0) && (out_nxt < MAX_OUT);
        end
        DRAIN: begin
          if (out_nxt == 8'd0 && rcv_nxt == {1'b0, xfer_q}) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign ctrl_err      = err_q;
  assign axi.m_arvalid = ar_valid_q;
  assign axi.m_araddr  = ar_addr_q;
  assign axi.m_arlen   = ar_len_q;

endmodule

// File: tb/tb_pc_core_rd_burst_ctrl.sv
// Bench for pc_core_rd_burst_ctrl: AR scoreboard fed by a burst-split model,
// an in-order R responder, a vector table and hand-written corner sequences.
module tb_pc_core_rd_burst_ctrl;
  localparam int AW  = 64;
  localparam int XW  = 32;
  localparam int BL  = 64;
  localparam int BPB = 64;
  localparam int MO  = 4;
  localparam int BIG = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic [XW-1:0] ctrl_xfer_beats = '0;
  logic          ctrl_busy, ctrl_done, ctrl_err;

  always #5 clk = ~clk;

  pc_core_rd_burst_ctrl_if #(.C_ADDR_WIDTH(AW)) axi ();

  pc_core_rd_burst_ctrl #(
    .C_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW), .C_BURST_LEN(BL),
    .C_BYTES_PER_BEAT(BPB), .C_MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_xfer_beats(ctrl_xfer_beats), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .ctrl_err(ctrl_err), .axi(axi)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] addr; logic [31:0] beats; int n_ars; logic [7:0] last_len; } vec_t;

  ar_t  exp_q[$];
  int   pend[$];
  int   n_checks = 0, n_err = 0;
  int   cyc = 0, ar_hs = 0, rl_cnt = 0, r_beats = 0, done_cnt = 0, done_base = 0;
  int   r_allow = 0, spur_cnt = 0, spur_seen = 0, hs_cyc = -1, rl_cyc = -1;
  int   cur_beats = 0, beat_base = 0;
  logic [7:0] last_len = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side model: scores ARs against the queue, returns R beats in order.
  initial begin
    ar_t e;
    axi.rd_beat = 1'b0;
    axi.rd_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        exp_q.delete();
        axi.rd_beat = 1'b0;
        axi.rd_last = 1'b0;
      end else begin
        if (ctrl_done) begin
          done_cnt++;
          if (cur_beats != 0) begin
            check("done_latency", cyc, rl_cyc + 1);
            check("done_beats", r_beats - beat_base, cur_beats);
            check("done_all_returned", pend.size(), 0);
          end
        end
        axi.rd_beat = 1'b0;
        axi.rd_last = 1'b0;
        if (spur_seen != spur_cnt) begin
          spur_seen++;
          axi.rd_beat = 1'b1;
          axi.rd_last = 1'b1;
        end else if (pend.size() > 0 && rl_cnt < r_allow) begin
          axi.rd_beat = 1'b1;
          r_beats++;
          if (pend[0] == 1) begin
            axi.rd_last = 1'b1;
            pend.delete(0);
            rl_cnt++;
            rl_cyc = cyc;
          end else begin
            pend[0] = pend[0] - 1;
          end
        end
        if (axi.m_arvalid && axi.m_arready) begin
          ar_hs++;
          hs_cyc   = cyc;
          last_len = axi.m_arlen;
          check("ar_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ar_addr", axi.m_araddr, e.addr);
            check("ar_len", axi.m_arlen, e.len);
          end
          pend.push_back(int'(axi.m_arlen) + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] ad;
    int rem, n;
    ar_t e;
    ad  = a;
    rem = int'(b);
    while (rem > 0) begin
      n = (rem > BL) ? BL : rem;
      e.addr = ad;
      e.len  = 8'(n - 1);
      exp_q.push_back(e);
      ad  = ad + 64'(n * BPB);
      rem = rem - n;
    end
    cur_beats       = int'(b);
    beat_base       = r_beats;
    done_base       = done_cnt;
    ctrl_addr       = a;
    ctrl_xfer_beats = b;
    ctrl_start      = 1'b1;
    tick();
    ctrl_start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == done_base && k < 3000) begin
      tick();
      k++;
    end
    check({name, "_done"}, done_cnt - done_base, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int base, rl0, k;
    vecs[0] = '{64'h1000, 32'd150, 3, 8'd21};
    vecs[1] = '{64'h0, 32'd64, 1, 8'd63};
    vecs[2] = '{64'h10000, 32'd1, 1, 8'd0};
    vecs[3] = '{64'h2000, 32'd640, 10, 8'd63};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_F000, 32'd129, 3, 8'd0};
    vecs[5] = '{64'h7000, 32'd0, 0, 8'd0};
    axi.m_arready = 1'b0;

    ticks(3);
    check("rst_busy", ctrl_busy, 0);
    check("rst_done", ctrl_done, 0);
    check("rst_err", ctrl_err, 0);
    check("rst_arvalid", axi.m_arvalid, 0);
    check("rst_araddr", axi.m_araddr, 0);
    check("rst_arlen", axi.m_arlen, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      base = ar_hs;
      r_allow = BIG;
      axi.m_arready = 1'b1;
      start_xfer(vecs[i].addr, vecs[i].beats);
      if (vecs[i].beats == 0) begin
        check("zero_done", ctrl_done, 1);
        check("zero_busy", ctrl_busy, 0);
        check("zero_arvalid", axi.m_arvalid, 0);
        tick();
        check("zero_done_pulse", ctrl_done, 0);
        check("zero_busy_after", ctrl_busy, 0);
      end else begin
        check("vec_busy", ctrl_busy, 1);
        check("vec_first_arvalid", axi.m_arvalid, 1);
        check("vec_first_araddr", axi.m_araddr, vecs[i].addr);
        wait_done("vec");
        check("vec_busy_end", ctrl_busy, 0);
        check("vec_last_len", last_len, vecs[i].last_len);
      end
      check("vec_err", ctrl_err, 0);
      check("vec_ar_count", ar_hs - base, vecs[i].n_ars);
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // AR backpressure: first request must hold steady until accepted.
    base = ar_hs;
    axi.m_arready = 1'b0;
    start_xfer(64'h1000, 32'd128);
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", axi.m_arvalid, 1);
      check("bp_araddr", axi.m_araddr, 64'h1000);
      check("bp_arlen", axi.m_arlen, 63);
      tick();
    end
    check("bp_no_hs", ar_hs - base, 0);
    axi.m_arready = 1'b1;
    tick();
    check("bp_hs_cycle6", ar_hs - base, 1);
    wait_done("bp");
    check("bp_ar_count", ar_hs - base, 2);

    // Outstanding limit, with an ignored start while busy.
    base = ar_hs;
    rl0 = rl_cnt;
    r_allow = rl_cnt;
    start_xfer(64'h20000, 32'd640);
    ticks(12);
    check("lim_ar4", ar_hs - base, 4);
    check("lim_arvalid_low", axi.m_arvalid, 0);
    ctrl_addr = 64'hDEAD_0000;
    ctrl_xfer_beats = 32'd5;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("lim_busy", ctrl_busy, 1);
    r_allow = rl_cnt + 1;
    ticks(80);
    check("lim_ar5", ar_hs - base, 5);
    check("lim_arvalid_low2", axi.m_arvalid, 0);
    r_allow = BIG;
    wait_done("lim");
    check("lim_ar10", ar_hs - base, 10);
    check("lim_rlast10", rl_cnt - rl0, 10);

    // AR handshake and rlast in the same cycle at outstanding = 3.
    base = ar_hs;
    rl0 = rl_cnt;
    r_allow = rl_cnt;
    start_xfer(64'h40000, 32'd640);
    ticks(10);
    check("sim_ar4", ar_hs - base, 4);
    axi.m_arready = 1'b0;
    r_allow = rl0 + 2;
    k = 0;
    while (!(pend.size() > 0 && pend[0] == 1 && rl_cnt == rl0 + 1) && k < 300) begin
      tick();
      k++;
    end
    check("sim_found", k < 300, 1);
    axi.m_arready = 1'b1;
    tick();
    check("sim_same_cycle", hs_cyc, rl_cyc);
    ticks(10);
    check("sim_ar6", ar_hs - base, 6);
    r_allow = BIG;
    wait_done("sim");
    check("sim_ar10", ar_hs - base, 10);

    // Spurious rlast while idle: sticky until the next start.
    spur_cnt++;
    ticks(2);
    check("spur_err", ctrl_err, 1);
    ticks(5);
    check("spur_err_sticky", ctrl_err, 1);
    check("spur_busy", ctrl_busy, 0);
    start_xfer(64'h30000, 32'd64);
    check("spur_err_clr", ctrl_err, 0);
    wait_done("spur");

    // Asynchronous reset mid-transfer, then a clean transfer.
    start_xfer(64'h50000, 32'd640);
    ticks(20);
    check("rstm_busy_before", ctrl_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstm_arvalid", axi.m_arvalid, 0);
    check("rstm_busy", ctrl_busy, 0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    check("rstm_arvalid_after", axi.m_arvalid, 0);
    base = ar_hs;
    start_xfer(64'h60000, 32'd64);
    wait_done("rstm");
    check("rstm_ar_count", ar_hs - base, 1);
    check("rstm_err", ctrl_err, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
